// File: rtl/bsg_store_unpacker_axil.sv
// Turns packed byte commands {write_not_read, addr[22:0], data[7:0]} into single AXI-lite
// transactions, one at a time. Read returns come back as a zero-extended byte on data_o.
module bsg_store_unpacker_axil #(
  parameter int axi_addr_width_p = 32,
  parameter int axi_data_width_p = 32,
  parameter logic [axi_addr_width_p-1:0] base_addr_p = '0
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,

  input  logic [31:0]                   data_i,
  input  logic                          v_i,
  output logic                          ready_o,

  output logic [31:0]                   data_o,
  output logic                          v_o,
  input  logic                          ready_i,

  output logic                          err_o,

  output logic [axi_addr_width_p-1:0]   m_axil_awaddr_o,
  output logic                          m_axil_awvalid_o,
  input  logic                          m_axil_awready_i,

  output logic [axi_data_width_p-1:0]   m_axil_wdata_o,
  output logic [axi_data_width_p/8-1:0] m_axil_wstrb_o,
  output logic                          m_axil_wvalid_o,
  input  logic                          m_axil_wready_i,

  input  logic [1:0]                    m_axil_bresp_i,
  input  logic                          m_axil_bvalid_i,
  output logic                          m_axil_bready_o,

  output logic [axi_addr_width_p-1:0]   m_axil_araddr_o,
  output logic                          m_axil_arvalid_o,
  input  logic                          m_axil_arready_i,

  input  logic [axi_data_width_p-1:0]   m_axil_rdata_i,
  input  logic [1:0]                    m_axil_rresp_i,
  input  logic                          m_axil_rvalid_i,
  output logic                          m_axil_rready_o
);

  localparam int strb_width_lp = axi_data_width_p / 8;
  localparam int lane_bits_lp  = $clog2(strb_width_lp);

  typedef enum logic [2:0] {
    e_ready, e_write, e_bresp, e_read, e_rresp, e_send
  } state_e;

  state_e      state_q;
  logic [30:0] cmd_q;      // command minus the direction bit, which only steers the FSM
  logic        aw_done_q;
  logic        w_done_q;
  logic        err_q;
  logic [7:0]  data_q;

  logic [22:0]             addr;
  logic [7:0]              wbyte;
  logic [lane_bits_lp-1:0] lane;
  logic [7:0]              rbyte;
  logic                    aw_done_n;
  logic                    w_done_n;

  assign addr  = cmd_q[30:8];
  assign wbyte = cmd_q[7:0];
  assign lane  = addr[lane_bits_lp-1:0];

  // Handshake outputs decode the state but are forced low while reset is held, so a reset
  // cycle never presents a half-finished beat to either side.
  assign ready_o          = reset_n_i & (state_q == e_ready);
  assign v_o              = reset_n_i & (state_q == e_send);
  assign m_axil_awvalid_o = reset_n_i & (state_q == e_write) & ~aw_done_q;
  assign m_axil_wvalid_o  = reset_n_i & (state_q == e_write) & ~w_done_q;
  assign m_axil_bready_o  = reset_n_i & (state_q == e_bresp);
  assign m_axil_arvalid_o = reset_n_i & (state_q == e_read);
  assign m_axil_rready_o  = reset_n_i & (state_q == e_rresp);

  assign m_axil_awaddr_o = base_addr_p | axi_addr_width_p'(addr);
  assign m_axil_araddr_o = base_addr_p | axi_addr_width_p'(addr);
  assign m_axil_wdata_o  = {strb_width_lp{wbyte}};

  assign data_o = {24'b0, data_q};
  assign err_o  = err_q;

  assign aw_done_n = aw_done_q | (m_axil_awvalid_o & m_axil_awready_i);
  assign w_done_n  = w_done_q  | (m_axil_wvalid_o  & m_axil_wready_i);

  // Byte-lane decode shared by the write strobe and the read-data select.
  always_comb begin
    m_axil_wstrb_o = '0;
    rbyte          = m_axil_rdata_i[7:0];
    for (int i = 0; i < strb_width_lp; i++) begin
      if (lane == lane_bits_lp'(i)) begin
        m_axil_wstrb_o[i] = 1'b1;
        rbyte             = m_axil_rdata_i[8*i +: 8];
      end
    end
  end

  // Command FSM with latched command, per-channel write progress, read byte and sticky error.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q   <= e_ready;
      cmd_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
    end else begin
      unique case (state_q)
        e_ready: begin
          if (v_i) begin
            cmd_q   <= data_i[30:0];
            state_q <= data_i[31] ? e_write : e_read;
          end
        end
        e_write: begin
          // AW and W complete independently; leave once both have been taken.
          if (aw_done_n && w_done_n) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= e_bresp;
          end else begin
            aw_done_q <= aw_done_n;
            w_done_q  <= w_done_n;
          end
        end
        e_bresp: begin
          if (m_axil_bvalid_i) begin
            if (m_axil_bresp_i != 2'b00) err_q <= 1'b1;
            state_q <= e_ready;
          end
        end
        e_read: begin
          if (m_axil_arready_i) state_q <= e_rresp;
        end
        e_rresp: begin
          if (m_axil_rvalid_i) begin
            if (m_axil_rresp_i != 2'b00) err_q <= 1'b1;
            data_q  <= rbyte;
            state_q <= e_send;
          end
        end
        e_send: begin
          if (ready_i) state_q <= e_ready;
        end
        default: state_q <= e_ready;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_store_unpacker_axil.sv
// Bench for bsg_store_unpacker_axil: table of byte commands against a small AXI-lite slave
// model, scoreboard queues for expected beats and read returns, plus hand-written corner cases.
module tb_bsg_store_unpacker_axil;

  localparam logic [31:0] Base = 32'h1080_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] data_i;
  logic        v_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        v_o;
  logic        ready_i;
  logic        err_o;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  always #5 clk = ~clk;

  bsg_store_unpacker_axil #(
    .axi_addr_width_p(32),
    .axi_data_width_p(32),
    .base_addr_p     (Base)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .data_i          (data_i),
    .v_i             (v_i),
    .ready_o         (ready_o),
    .data_o          (data_o),
    .v_o             (v_o),
    .ready_i         (ready_i),
    .err_o           (err_o),
    .m_axil_awaddr_o (awaddr),
    .m_axil_awvalid_o(awvalid),
    .m_axil_awready_i(awready),
    .m_axil_wdata_o  (wdata),
    .m_axil_wstrb_o  (wstrb),
    .m_axil_wvalid_o (wvalid),
    .m_axil_wready_i (wready),
    .m_axil_bresp_i  (bresp),
    .m_axil_bvalid_i (bvalid),
    .m_axil_bready_o (bready),
    .m_axil_araddr_o (araddr),
    .m_axil_arvalid_o(arvalid),
    .m_axil_arready_i(arready),
    .m_axil_rdata_i  (rdata),
    .m_axil_rresp_i  (rresp),
    .m_axil_rvalid_i (rvalid),
    .m_axil_rready_o (rready)
  );

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } wexp_t;

  vec_t        vecs [8];
  wexp_t       wq [$];
  logic [31:0] raq [$];
  logic [31:0] rq [$];

  int checks = 0;
  int errors = 0;

  // Slave model knobs
  int          aw_lat = 0, w_lat = 0, ar_lat = 0;
  logic        hold_r = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;

  // Slave model state
  int   aw_wait = 0, w_wait = 0, ar_wait = 0;
  int   aw_beats = 0, w_beats = 0;
  logic b_pend = 1'b0, r_pend = 1'b0, got_aw = 1'b0, got_w = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave and monitor: drive slave outputs on the falling edge and record the handshakes
  // that the following rising edge will complete.
  always @(negedge clk) begin
    if (!reset_n) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
      aw_wait = 0; w_wait = 0; ar_wait = 0;
      b_pend = 1'b0; r_pend = 1'b0; got_aw = 1'b0; got_w = 1'b0;
    end else begin
      awready = awvalid && (aw_wait >= aw_lat);
      aw_wait = (awvalid && !awready) ? aw_wait + 1 : 0;
      wready  = wvalid && (w_wait >= w_lat);
      w_wait  = (wvalid && !wready) ? w_wait + 1 : 0;
      arready = arvalid && (ar_wait >= ar_lat);
      ar_wait = (arvalid && !arready) ? ar_wait + 1 : 0;
      bvalid  = b_pend;
      bresp   = bresp_cfg;
      rvalid  = r_pend && !hold_r;
      rresp   = rresp_cfg;
      rdata   = rdata_cfg;
      if (bvalid && bready) b_pend = 1'b0;
      if (rvalid && rready) r_pend = 1'b0;
      if (awvalid && awready) begin
        aw_beats++;
        if (wq.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          check("awaddr", awaddr, wq[0].addr);
          check("aw_once", got_aw, 0);
        end
        got_aw = 1'b1;
      end
      if (wvalid && wready) begin
        w_beats++;
        if (wq.size() == 0) check("w_unexpected", 1, 0);
        else begin
          check("wdata", wdata, wq[0].wdata);
          check("wstrb", wstrb, wq[0].wstrb);
          check("w_once", got_w, 0);
        end
        got_w = 1'b1;
      end
      if (got_aw && got_w) begin
        got_aw = 1'b0;
        got_w  = 1'b0;
        if (wq.size() > 0) void'(wq.pop_front());
        b_pend = 1'b1;
      end
      if (arvalid && arready) begin
        if (raq.size() == 0) check("ar_unexpected", 1, 0);
        else check("araddr", araddr, raq.pop_front());
        r_pend = 1'b1;
      end
      if (v_o) begin
        if (rq.size() == 0) check("v_o_spurious", 1, 0);
        else if (ready_i) check("data_o", data_o, rq.pop_front());
      end
    end
  end

  // Present a command from the posedge+1 phase; returns posedge+1 after it is taken.
  task automatic accept_cmd(input vec_t v);
    int ok = 0;
    int g  = 0;
    rdata_cfg = v.rdata;
    data_i    = v.cmd;
    v_i       = 1'b1;
    while (ok == 0 && g < 50) begin
      @(negedge clk);
      if (ready_o) ok = 1;
      else begin
        @(posedge clk); #1;
        g++;
      end
    end
    check("accept", ok, 1);
    if (ok != 0) begin
      if (v.cmd[31]) wq.push_back('{addr: v.exp_addr, wdata: v.exp_wdata, wstrb: v.exp_wstrb});
      else begin
        raq.push_back(v.exp_addr);
        rq.push_back(v.exp_data);
      end
    end
    @(posedge clk); #1;
    v_i = 1'b0;
  endtask

  // Falling edges after acceptance until v_o (reads) or ready_o (writes) appears.
  task automatic wait_lat(input logic want_vo, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(want_vo ? v_o : ready_o) && n < 100);
  endtask

  task automatic wait_idle();
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!ready_o && g < 200);
    check("idle", ready_o, 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_err", err_o, 0);
    check("rst_data", data_o, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int a0, w0;
    int g;
    //        cmd            rdata          addr           wdata          wstrb    data
    vecs[0] = '{32'h8000_12A5, 32'h0,         32'h1080_0012, 32'hA5A5_A5A5, 4'b0100, 32'h0};
    vecs[1] = '{32'hFFFF_FF3C, 32'h0,         32'h10FF_FFFF, 32'h3C3C_3C3C, 4'b1000, 32'h0};
    vecs[2] = '{32'h8000_0000, 32'h0,         32'h1080_0000, 32'h0000_0000, 4'b0001, 32'h0};
    vecs[3] = '{32'h8001_01FF, 32'h0,         32'h1080_0101, 32'hFFFF_FFFF, 4'b0010, 32'h0};
    vecs[4] = '{32'h0000_0302, 32'h4433_2211, 32'h1080_0003, 32'h0,         4'b0000, 32'h44};
    vecs[5] = '{32'h0000_0055, 32'hDEAD_BEEF, 32'h1080_0000, 32'h0,         4'b0000, 32'hEF};
    vecs[6] = '{32'h0000_0100, 32'hDEAD_BEEF, 32'h1080_0001, 32'h0,         4'b0000, 32'hBE};
    vecs[7] = '{32'h7FFF_FE00, 32'hCAFE_F00D, 32'h10FF_FFFE, 32'h0,         4'b0000, 32'hFE};

    reset_n = 1'b0; v_i = 1'b0; data_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_o", ready_o, 0);
    check("rst_v_o", v_o, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_err", err_o, 0);
    check("rst_data", data_o, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", ready_o, 1);
    @(posedge clk); #1;

    // Table: every vector with an immediate slave, checking minimum latency.
    for (int i = 0; i < 8; i++) begin
      accept_cmd(vecs[i]);
      wait_lat(!vecs[i].cmd[31], n);
      check("latency", n, 3);
      wait_idle();
    end

    // Read held by back-pressure.
    ready_i = 1'b0;
    accept_cmd(vecs[4]);
    wait_lat(1'b1, n);
    check("bp_latency", n, 3);
    repeat (5) begin
      check("bp_v_o", v_o, 1);
      check("bp_ready_o", ready_o, 0);
      check("bp_data_o", data_o, 32'h44);
      @(negedge clk);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    wait_idle();

    // W accepted three cycles ahead of AW.
    aw_lat = 3;
    a0 = aw_beats; w0 = w_beats;
    accept_cmd(vecs[1]);
    @(negedge clk);
    check("skew_awvalid1", awvalid, 1);
    check("skew_wvalid1", wvalid, 1);
    @(negedge clk);
    check("skew_awvalid2", awvalid, 1);
    check("skew_wvalid2", wvalid, 0);
    @(negedge clk);
    check("skew_awvalid3", awvalid, 1);
    wait_idle();
    check("skew_aw_beats", aw_beats - a0, 1);
    check("skew_w_beats", w_beats - w0, 1);
    aw_lat = 0;

    // AW ahead of W.
    w_lat = 2;
    a0 = aw_beats; w0 = w_beats;
    accept_cmd(vecs[3]);
    wait_idle();
    check("skew2_aw_beats", aw_beats - a0, 1);
    check("skew2_w_beats", w_beats - w0, 1);
    w_lat = 0;

    // Sticky error from a read response.
    rresp_cfg = 2'b10;
    accept_cmd(vecs[5]);
    wait_idle();
    check("err_rresp", err_o, 1);
    rresp_cfg = 2'b00;
    accept_cmd(vecs[0]);
    wait_idle();
    accept_cmd(vecs[6]);
    wait_idle();
    check("err_sticky", err_o, 1);
    pulse_reset();

    // Sticky error from a write response.
    bresp_cfg = 2'b11;
    accept_cmd(vecs[2]);
    wait_idle();
    check("err_bresp", err_o, 1);
    bresp_cfg = 2'b00;
    pulse_reset();

    // Reset while waiting for read data.
    hold_r = 1'b1;
    accept_cmd(vecs[7]);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!rready && g < 20);
    check("reach_rresp", rready, 1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    rq.delete();
    raq.delete();
    @(negedge clk);
    check("midrst_ready_o", ready_o, 0);
    check("midrst_rready", rready, 0);
    @(posedge clk); #1;
    hold_r  = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_ready_o", ready_o, 1);
    check("postrst_v_o", v_o, 0);
    @(posedge clk); #1;
    accept_cmd(vecs[7]);
    wait_lat(1'b1, n);
    check("postrst_latency", n, 3);
    wait_idle();

    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);
    check("raq_empty", raq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
